// File: rtl/lsu_ctrl.sv
// Load/store sequencer in front of a byte-addressed data memory: decodes RV32I
// funct3, range-checks, and either issues one native access or splits misaligned ones into bytes.
module lsu_ctrl #(
  parameter int unsigned MEM_BYTES      = 32,
  parameter bit          MISALIGN_SPLIT = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [3:0]  mem_rEN,
  output logic [3:0]  mem_wEN,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_SPLIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_fault_q, rsp_fault_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [3:0]  mem_ren_q, mem_ren_d;
  logic [3:0]  mem_wen_q, mem_wen_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        illegal, out_of_range, misaligned;
  logic [2:0]  req_size;
  logic [32:0] req_end;
  logic [31:0] buf_nxt;
  logic [1:0]  cnt_nxt;

  function automatic logic [2:0] size_of(input logic [1:0] f);
    case (f)
      2'd0:    size_of = 3'd1;
      2'd1:    size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] rd_code(input logic [2:0] f3);
    case (f3)
      3'd2:    rd_code = 4'b1000;
      3'd1:    rd_code = 4'b0010;
      3'd5:    rd_code = 4'b1010;
      3'd0:    rd_code = 4'b0001;
      3'd4:    rd_code = 4'b1001;
      default: rd_code = 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] wr_code(input logic [2:0] f3);
    case (f3)
      3'd2:    wr_code = 4'b1000;
      3'd1:    wr_code = 4'b0010;
      3'd0:    wr_code = 4'b0001;
      default: wr_code = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] f3);
    case (f3)
      3'd0:    extend = {{24{d[7]}}, d[7:0]};
      3'd4:    extend = {24'h0, d[7:0]};
      3'd1:    extend = {{16{d[15]}}, d[15:0]};
      3'd5:    extend = {16'h0, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  always_comb begin
    req_size     = size_of(req_funct3[1:0]);
    req_end      = {1'b0, req_addr} + {30'h0, req_size};
    illegal      = req_we ? (req_funct3 > 3'd2)
                          : !(req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    out_of_range = req_end > 33'(MEM_BYTES);
    misaligned   = (req_size == 3'd2) ? req_addr[0]
                 : (req_size == 3'd4) ? (req_addr[1:0] != 2'b00) : 1'b0;

    cnt_nxt = cnt_q + 2'd1;
    buf_nxt = buf_q;
    buf_nxt[{cnt_q, 3'b000} +: 8] = mem_rdata[7:0];

    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    rsp_valid_d = rsp_valid_q;
    rsp_fault_d = rsp_fault_q;
    rsp_rdata_d = rsp_rdata_q;
    // Memory port outputs are registered and describe the next cycle only.
    mem_ren_d   = '0;
    mem_wen_d   = '0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          cnt_d    = '0;
          buf_d    = '0;
          if (illegal || out_of_range || (misaligned && !MISALIGN_SPLIT)) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
            rsp_rdata_d = '0;
          end else if (misaligned) begin
            state_d    = S_SPLIT;
            mem_addr_d = req_addr;
            if (req_we) begin
              mem_wen_d   = 4'b0001;
              mem_wdata_d = {24'h0, req_wdata[7:0]};
            end else begin
              mem_ren_d = 4'b1001;
            end
          end else begin
            state_d    = S_ACCESS;
            mem_addr_d = req_addr;
            if (req_we) begin
              mem_wen_d   = wr_code(req_funct3);
              mem_wdata_d = req_wdata;
            end else begin
              mem_ren_d = rd_code(req_funct3);
            end
          end
        end
      end
      S_ACCESS: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = we_q ? '0 : mem_rdata;
      end
      S_SPLIT: begin
        buf_d = buf_nxt;
        if ({1'b0, cnt_q} == size_of(funct3_q[1:0]) - 3'd1) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? '0 : extend(buf_nxt, funct3_q);
        end else begin
          cnt_d      = cnt_nxt;
          mem_addr_d = addr_q + {30'h0, cnt_nxt};
          if (we_q) begin
            mem_wen_d   = 4'b0001;
            mem_wdata_d = {24'h0, wdata_q[{cnt_nxt, 3'b000} +: 8]};
          end else begin
            mem_ren_d = 4'b1001;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_fault_d = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      buf_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= '0;
      mem_ren_q   <= '0;
      mem_wen_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_ren_q   <= mem_ren_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Gated by RST so ready drops immediately on an asynchronous reset.
  assign req_ready = !RST && (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_rEN   = mem_ren_q;
  assign mem_wEN   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
